pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised elastic pipeline register: the general-purpose successor of the fixed inter-stage latches between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field with a valid/ready handshake, and supports stall back-pressure and flush (bubble insertion). A bubble always presents all-zero control, so no RegWrite or MemWrite can leak. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- CTRL_W, default 8: control field width (RegWrite, MemtoReg, MemWrite, Load/Save type, ...); forced to 0 in bubbles.
- DATA_W, default 69: data field width (ALU result, store data, write-register index, ...); not cleared by bubbles.
- CNT_W, default 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries and of the current input.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage accepts the entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_ctrl  out  CTRL_W  held control; 0 whenever out_valid=0.
- out_data  out  DATA_W  held data; holds its last value when invalid.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates.

## Operation
- Input transfer happens when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
- Main register is {m_valid, m_ctrl, m_data}, and out_* = main register. On output transfer without a refill, m_valid←0 and m_ctrl←0.
- Control zeroing: any entry written as invalid gets ctrl=0. out_ctrl is therefore 0 whenever out_valid=0, by register content and not by output gating.
- Flush (highest priority): m_valid←0, ctrl←0 in all entries, input on the flush cycle is discarded, stall_cnt unaffected. A simultaneous output transfer on the flush cycle still counts as consumed downstream.
- stall_cnt increments when out_valid & ~out_ready & ~flush, and stops at 2^CNT_W−1.
- Reset: m_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid cleared (if present). in_ready=1 in the first cycle after reset release.
- Without PIPE_SKID_EN:
  - in_ready = ~m_valid | out_ready (combinational from out_ready).
  - On input transfer, the main register loads in_*, with simultaneous drain allowed. This gives full throughput.
- With PIPE_SKID_EN:
  - Adds a skid register {s_valid, s_ctrl, s_data}. in_ready = ~s_valid, which is registered; there is no out_ready→in_ready path.
  - Accept into main if main is empty or draining this cycle and s_valid=0. Otherwise accept into skid.
  - When main drains and s_valid=1: main←skid and s_valid←0 in the same cycle. An input arriving that cycle is not possible because in_ready=0.
  - Order is preserved strictly FIFO; capacity is 2 entries.

## Timing
- Latency: in_* at edge N appears on out_* after edge N (1 cycle), in both configurations.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Without skid: a stall (out_ready=0 with m_valid=1) drops in_ready in the same cycle.
- With skid: in_ready drops one cycle after the second entry is captured. It rises the cycle after the skid empties into main.
- Flush: out_valid=0 and in_ready=1 on the cycle after the flush edge.
- Reset assertion mid-transfer: all entries are lost immediately (asynchronous); no partial update.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid buffer, registered in_ready, full throughput with no combinational ready path.
- PIPE_SKID_EN undefined: single register, combinational in_ready.
- In both builds, flush, control zeroing and the stall counter are identical.

## Test plan
- Reset then stream: in_valid=1 for 4 cycles, data 0x1..0x4, out_ready=1 → out_data 0x1..0x4 on cycles 1..4 with out_valid=1; out_ctrl matches in_ctrl.
- Stall: hold out_ready=0 for 3 cycles with main full → out_data held, stall_cnt=3.
  - Skid build: exactly one extra entry accepted, then in_ready=0.
  - No-skid build: in_ready=0 immediately.
- Release after stall → entries emerge in order with no loss or duplication, 1 per cycle.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears.
- Counter saturation with CNT_W=4: stall 20 cycles → stall_cnt=15 and holds.
- Async reset asserted between edges while full → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 immediately.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying a control and a data field over a
// valid/ready handshake, with flush (bubble insertion) and a saturating
// stall-cycle counter. Bubbles always hold all-zero control.
// Optional feature: define PIPE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single register with combinational ready.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = m_valid_q & out_ready;

`ifdef PIPE_SKID_EN
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  // Ready depends only on skid occupancy, so there is no out_ready->in_ready path.
  assign in_ready = ~s_valid_q;

  // Next state for main and skid entries; flush wins, skid refills main first.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (s_valid_q) begin
      // Skid full implies main full; no input can arrive since in_ready=0.
      if (out_ready) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end
    end else if (in_xfer) begin
      if (~m_valid_q | out_ready) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end
    end else if (out_xfer) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
  end

  // Skid entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end
`else
  // Accept whenever main is empty or being drained this cycle.
  assign in_ready = ~m_valid_q | out_ready;

  // Next state for the main entry; flush wins, a load may coincide with a drain.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (in_xfer) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = in_ctrl;
      m_data_d  = in_data;
    end else if (out_xfer) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
  end
`endif

  // Saturating count of cycles where a presented entry is not taken.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && !flush && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  // Main entry and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule
